// File: rtl/fpu_pkg.sv
// Shared FPU types and helpers: divider FSM states, canonical NaN
// and operand classification for any exponent/mantissa split.
package fpu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      DIV,
      ROUND,
      DONE
   } fdiv_state_t;

   localparam int FMAXW = 128;

   function automatic logic [FMAXW-1:0] ones(input int n);
      return (FMAXW'(1) << n) - FMAXW'(1);
   endfunction

   // {0, all-ones exponent, quiet bit, zeros}
   function automatic logic [FMAXW-1:0] qnan(input int ew, input int mw);
      return ones(ew + 1) << (mw - 1);
   endfunction

   function automatic logic is_zero(input logic [FMAXW-1:0] e);
      return e == '0;
   endfunction

   function automatic logic is_inf(input logic [FMAXW-1:0] e,
                                   input logic [FMAXW-1:0] m,
                                   input int ew);
      return (e == ones(ew)) && (m == '0);
   endfunction

   function automatic logic is_nan(input logic [FMAXW-1:0] e,
                                   input logic [FMAXW-1:0] m,
                                   input int ew);
      return (e == ones(ew)) && (m != '0);
   endfunction

endpackage

// File: rtl/fdiv_round.sv
// Round-to-nearest-even and pack of a normalised quotient, with
// overflow to infinity and flush-to-zero on underflow.
module fdiv_round #(
   parameter int EW = 8,
   parameter int MW = 23
) (
   input  logic                sign,
   input  logic signed [EW+1:0] e,
   input  logic [MW+1:0]       q,
   input  logic                sticky,
   output logic [EW+MW:0]      y
);

   localparam logic signed [EW+1:0] EMAX = (EW+2)'((2 ** EW) - 1);
   localparam logic signed [EW+1:0] EONE = (EW+2)'(1);
   localparam logic signed [EW+1:0] EZERO = '0;

   logic                inc;
   logic [MW+1:0]       sum;
   logic                carry;
   logic [MW-1:0]       mant_r;
   logic signed [EW+1:0] e_r;

   // q = {hidden, mantissa, guard}
   assign inc    = q[0] & (sticky | q[1]);
   assign sum    = {1'b0, q[MW+1:1]} + (MW+2)'(inc);
   assign carry  = sum[MW+1];
   assign mant_r = carry ? sum[MW:1] : sum[MW-1:0];
   assign e_r    = carry ? e + EONE : e;

   always_comb begin
      y = {sign, e_r[EW-1:0], mant_r};
      if (e_r >= EMAX) begin
         y = {sign, {EW{1'b1}}, {MW{1'b0}}};
      end else if (e_r <= EZERO) begin
         y = {sign, {(EW+MW){1'b0}}};
      end
   end

endmodule

// File: rtl/fdiv_seq.sv
// Sequential restoring floating-point divider, one quotient bit per
// cycle, valid/ready on both sides, RNE rounding, DAZ/FTZ.
module fdiv_seq
   import fpu_pkg::*;
#(
   parameter int EW = 8,
   parameter int MW = 23
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [EW+MW:0]    x1,
   input  logic [EW+MW:0]    x2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [EW+MW:0]    y,
   output logic              ovf
);

   localparam int W    = 1 + EW + MW;
   localparam int EXW  = EW + 2;
   localparam int CW   = $clog2(MW + 3);
   localparam int BIAS = (2 ** (EW - 1)) - 1;
   localparam logic signed [EXW-1:0] EONE = EXW'(1);

   fdiv_state_t          state_q, state_d;
   logic [W-1:0]         x1_q, x1_d, x2_q, x2_d;
   logic [MW+1:0]        rem_q, rem_d;
   logic [MW:0]          div_q, div_d;
   logic [MW+2:0]        q_q, q_d;
   logic signed [EXW-1:0] e_q, e_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 sign_q, sign_d;
   logic [W-1:0]         y_q, y_d;
   logic                 ovf_q, ovf_d;
   logic                 out_valid_q, out_valid_d;

   logic [EW-1:0]        e1, e2;
   logic [MW-1:0]        m1, m2;
   logic                 z1, z2, i1, i2, n1, n2, fin_in;
   logic                 ge;
   logic [MW+1:0]        rem_sub;
   logic [MW+1:0]        q_n;
   logic signed [EXW-1:0] e_n, e_pre;
   logic                 sticky_n;
   logic [W-1:0]         y_rnd;

   assign e1 = x1_q[W-2:MW];
   assign e2 = x2_q[W-2:MW];
   assign m1 = x1_q[MW-1:0];
   assign m2 = x2_q[MW-1:0];

   assign z1 = is_zero(FMAXW'(e1));
   assign z2 = is_zero(FMAXW'(e2));
   assign i1 = is_inf(FMAXW'(e1), FMAXW'(m1), EW);
   assign i2 = is_inf(FMAXW'(e2), FMAXW'(m2), EW);
   assign n1 = is_nan(FMAXW'(e1), FMAXW'(m1), EW);
   assign n2 = is_nan(FMAXW'(e2), FMAXW'(m2), EW);
   assign fin_in = (e1 != '1) && (e2 != '1);

   assign e_pre = $signed({2'b00, e1}) - $signed({2'b00, e2})
                + EXW'(BIAS);

   assign ge      = rem_q >= {1'b0, div_q};
   assign rem_sub = ge ? rem_q - {1'b0, div_q} : rem_q;

   // Quotient lies in (0.5, 2): renormalise when the integer bit is 0
   assign q_n      = q_q[MW+2] ? q_q[MW+2:1] : q_q[MW+1:0];
   assign e_n      = q_q[MW+2] ? e_q : e_q - EONE;
   assign sticky_n = (rem_q != '0) | (q_q[MW+2] & q_q[0]);

   fdiv_round #(
      .EW (EW),
      .MW (MW)
   ) u_round (
      .sign   (sign_q),
      .e      (e_n),
      .q      (q_n),
      .sticky (sticky_n),
      .y      (y_rnd)
   );

   always_comb begin
      state_d     = state_q;
      x1_d        = x1_q;
      x2_d        = x2_q;
      rem_d       = rem_q;
      div_d       = div_q;
      q_d         = q_q;
      e_d         = e_q;
      cnt_d       = cnt_q;
      sign_d      = sign_q;
      y_d         = y_q;
      ovf_d       = ovf_q;
      out_valid_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               x1_d    = x1;
               x2_d    = x2;
               state_d = PREP;
            end
         end
         PREP: begin
            sign_d  = x1_q[W-1] ^ x2_q[W-1];
            state_d = DONE;
            if (n1 | n2 | (z1 & z2) | (i1 & i2)) begin
               y_d = W'(qnan(EW, MW));
            end else if (i1 | z2) begin
               y_d = {sign_d, {EW{1'b1}}, {MW{1'b0}}};
            end else if (z1 | i2) begin
               y_d = {sign_d, {(EW+MW){1'b0}}};
            end else begin
               rem_d   = {1'b0, 1'b1, m1};
               div_d   = {1'b1, m2};
               q_d     = '0;
               e_d     = e_pre;
               cnt_d   = CW'(MW + 2);
               state_d = DIV;
            end
            ovf_d = fin_in & (y_d[W-2:MW] == '1);
         end
         DIV: begin
            rem_d = {rem_sub[MW:0], 1'b0};
            q_d   = {q_q[MW+1:0], ge};
            if (cnt_q == '0) begin
               state_d = ROUND;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ROUND: begin
            y_d     = y_rnd;
            ovf_d   = fin_in & (y_rnd[W-2:MW] == '1);
            state_d = DONE;
         end
         DONE: begin
            // valid follows one edge after the result register settles
            out_valid_d = 1'b1;
            if (out_valid_q & out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         x1_q        <= '0;
         x2_q        <= '0;
         rem_q       <= '0;
         div_q       <= '0;
         q_q         <= '0;
         e_q         <= '0;
         cnt_q       <= '0;
         sign_q      <= 1'b0;
         y_q         <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         x1_q        <= x1_d;
         x2_q        <= x2_d;
         rem_q       <= rem_d;
         div_q       <= div_d;
         q_q         <= q_d;
         e_q         <= e_d;
         cnt_q       <= cnt_d;
         sign_q      <= sign_d;
         y_q         <= y_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq: single precision vectors, backpressure,
// reset mid-division and a double-precision instance vs real division.
module tb_fdiv_seq;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] x1 = '0;
   logic [31:0] x2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] y;
   logic        ovf;

   logic        dv = 1'b0;
   logic        drdy;
   logic [63:0] dx1 = '0;
   logic [63:0] dx2 = '0;
   logic        dov;
   logic [63:0] dy;
   logic        dovf;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fdiv_seq #(.EW(8), .MW(23)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x1        (x1),
      .x2        (x2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .ovf       (ovf)
   );

   fdiv_seq #(.EW(11), .MW(52)) dut_d (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (dv),
      .in_ready  (drdy),
      .x1        (dx1),
      .x2        (dx2),
      .out_valid (dov),
      .out_ready (1'b1),
      .y         (dy),
      .ovf       (dovf)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // accept, wait for out_valid, check, then let the transfer happen
   task automatic run_s(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ey, input logic eovf,
                        input int elat, input string tag);
      int lat;
      @(negedge clk);
      x1 = a;
      x2 = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1 lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(elat));
      chk({tag, "_y"}, 64'(y), 64'(ey));
      chk({tag, "_ovf"}, 64'(ovf), 64'(eovf));
      @(posedge clk);
      #1;
   endtask

   task automatic run_d(input logic [63:0] a, input logic [63:0] b,
                        input string tag);
      int lat;
      logic [63:0] ey;
      ey = $realtobits($bitstoreal(a) / $bitstoreal(b));
      @(negedge clk);
      dx1 = a;
      dx2 = b;
      dv = 1'b1;
      @(posedge clk);
      #1 dv = 1'b0;
      lat = 0;
      while (!dov && lat < 200) begin
         @(posedge clk);
         #1 lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'd58);
      chk({tag, "_y"}, dy, ey);
      chk({tag, "_ovf"}, 64'(dovf), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] ra, rb;
      logic [31:0] hy;
      logic        hovf;

      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_y", 64'(y), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      run_s(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 29, "six_two");
      run_s(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 29, "one_three");
      run_s(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 1'b1, 29, "ovf_fin");
      run_s(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 2, "div_zero");
      run_s(32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 2, "zero_zero");
      run_s(32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 2, "inf_one");
      run_s(32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 29, "ftz_pos");
      run_s(32'h80800000, 32'h40000000, 32'h80000000, 1'b0, 29, "ftz_neg");
      run_s(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 2, "nan_in");
      run_s(32'hC0C00000, 32'h7F800000, 32'h80000000, 1'b0, 2, "fin_inf");

      // backpressure, with x1 disturbed while the division runs
      out_ready = 1'b0;
      @(negedge clk);
      x1 = 32'h3F800000;
      x2 = 32'h40400000;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 x1 = 32'h7F800000;
      for (int i = 0; i < 60 && !out_valid; i++) begin
         @(posedge clk);
         #1;
      end
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_y", 64'(y), 64'h3EAAAAAB);
      hy = y;
      hovf = ovf;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_valid", 64'(out_valid), 64'd1);
         chk("bp_hold_y", 64'(y), 64'(hy));
         chk("bp_hold_ovf", 64'(ovf), 64'(hovf));
         chk("bp_hold_inrdy", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_xfer_valid", 64'(out_valid), 64'd0);
      chk("bp_xfer_inrdy", 64'(in_ready), 64'd1);

      // reset during the tenth division cycle
      @(negedge clk);
      x1 = 32'h3F800000;
      x2 = 32'h40400000;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 rstn = 1'b0;
      #1;
      chk("rst_div_valid", 64'(out_valid), 64'd0);
      chk("rst_div_inrdy", 64'(in_ready), 64'd1);
      chk("rst_div_y", 64'(y), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_next_valid", 64'(out_valid), 64'd0);
      chk("rst_next_inrdy", 64'(in_ready), 64'd1);
      run_s(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 29, "post_rst");

      // double precision against real-valued division
      run_d(64'h4018000000000000, 64'h4000000000000000, "d_six_two");
      run_d(64'h3FF0000000000000, 64'h4008000000000000, "d_one_three");
      for (int i = 0; i < 8; i++) begin
         ra = {1'($urandom_range(0, 1)), 11'($urandom_range(823, 1223)),
               20'($urandom), 32'($urandom)};
         rb = {1'($urandom_range(0, 1)), 11'($urandom_range(823, 1223)),
               20'($urandom), 32'($urandom)};
         run_d(ra, rb, "d_rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
